fork_arbiter: RTL and testbench

- Central table controller: the responder side of the dining-philosophers handshake. Philosopher blocks raise a hungry request and drop a release when done eating.
- Grants eating rights (both forks) to N seats on a ring. Adjacent seats are never granted at the same time, and grants rotate round-robin.
- Deterministic: contains no nondeterministic inputs. Sits between N philosopher instances and the top-level model, and exposes starvation flags for property checking.

---
 rtl/fork_arbiter.sv | 143 ++++++++++++++
 tb/tb_fork_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fork_arbiter.sv
// -----------------------------------------------------------------------------
// fork_arbiter
//
// Central table controller for a ring of N dining philosophers. Each seat
// raises a level request when hungry and pulses done when it has finished
// eating. The arbiter grants both forks to a seat only when neither neighbour
// is eating or being granted in the same cycle. Seats are scanned round-robin
// from a rotating start pointer.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   req      [N-1:0]     level request (hungry) per seat
//   done     [N-1:0]     release pulse per seat, honoured only while eating
//   grant    [N-1:0]     seat i holds both forks (decoded from state register)
//   waiting  [N-1:0]     seat i is in WAIT (decoded from state register)
//   starve   [N-1:0]     wait counter of seat i has saturated at LIMIT
//   ptr      [PTR_W-1:0] round-robin start index for the next scan
// -----------------------------------------------------------------------------
module fork_arbiter #(
  parameter int N      = 4,
  parameter int WAIT_W = 4,
  parameter int LIMIT  = 12,
  parameter int PTR_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     waiting,
  output logic [N-1:0]     starve,
  output logic [PTR_W-1:0] ptr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EAT  = 2'd2
  } seat_e;

  localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(LIMIT);

  seat_e             r_state     [N];
  seat_e             w_state_nxt [N];
  logic [WAIT_W-1:0] r_cnt       [N];
  logic [WAIT_W-1:0] w_cnt_nxt   [N];
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;

  logic [N-1:0] w_elig;  // requesting and not already eating
  logic [N-1:0] w_eat;   // currently eating, including a seat pulsing done
  logic [N-1:0] w_gnt;   // granted by this cycle's scan

  always_comb begin : seat_decode
    for (int i = 0; i < N; i++) begin
      w_eat[i]  = (r_state[i] == S_EAT);
      w_elig[i] = req[i] && (r_state[i] != S_EAT);
    end
  end

  // Round-robin scan. A seat sees grants already handed out to seats visited
  // before it, so the last seat in the order also respects the first one.
  always_comb begin : grant_scan
    int idx;
    int lft;
    int rgt;
    // NOTE: every variable written here gets a default before any condition,
    // otherwise the tool infers a latch to hold the old value.
    w_gnt     = '0;
    w_ptr_nxt = r_ptr;
    idx       = 0;
    lft       = 0;
    rgt       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      lft = (idx == 0)     ? N - 1 : idx - 1;
      rgt = (idx == N - 1) ? 0     : idx + 1;
      if (w_elig[idx] && !w_eat[lft] && !w_eat[rgt] &&
          !w_gnt[lft] && !w_gnt[rgt]) begin
        w_gnt[idx] = 1'b1;
        // Later grants in scan order overwrite, leaving last-granted + 1.
        w_ptr_nxt  = PTR_W'(rgt);
      end
    end
  end

  // Per-seat next state and wait counter. The counter advances on every
  // cycle the seat is requesting but left ungranted, so it counts the cycles
  // spent in WAIT.
  always_comb begin : seat_next
    for (int i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (r_state[i] == S_EAT) begin
        if (done[i]) w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i] = '0;
      end else if (w_gnt[i]) begin
        w_state_nxt[i] = S_EAT;
        w_cnt_nxt[i]   = '0;
      end else if (req[i]) begin
        w_state_nxt[i] = S_WAIT;
        if (r_cnt[i] != LIMIT_C) w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end else begin
        // Withdrawal from WAIT, or staying idle.
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
      end
    end
  end

  // NOTE: these per-seat arrays are a handful of flops, not a RAM, so they
  // can and must be reset; a real memory array would not be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
      r_ptr <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_ptr <= w_ptr_nxt;
    end
  end

  always_comb begin : out_decode
    for (int i = 0; i < N; i++) begin
      grant[i]   = (r_state[i] == S_EAT);
      waiting[i] = (r_state[i] == S_WAIT);
      starve[i]  = (r_cnt[i] == LIMIT_C);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: tb/tb_fork_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fork_arbiter
//
// Directed scenarios on a 4-seat arbiter, then a long random run on a 5-seat
// arbiter driven by simple philosopher models, with safety invariants checked
// every cycle and the longest observed wait bounded.
// -----------------------------------------------------------------------------
module tb_fork_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [3:0] waiting;
  logic [3:0] starve;
  logic [1:0] ptr;

  logic [4:0] req5;
  logic [4:0] done5;
  logic [4:0] grant5;
  logic [4:0] waiting5;
  logic [4:0] starve5;
  logic [2:0] ptr5;

  int n_pass;
  int n_total;

  fork_arbiter #(.N(4), .WAIT_W(4), .LIMIT(12), .PTR_W(2)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .waiting (waiting),
    .starve  (starve),
    .ptr     (ptr)
  );

  fork_arbiter #(.N(5), .WAIT_W(4), .LIMIT(12), .PTR_W(3)) u_dut5 (
    .clk     (clk),
    .reset   (reset),
    .req     (req5),
    .done    (done5),
    .grant   (grant5),
    .waiting (waiting5),
    .starve  (starve5),
    .ptr     (ptr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    done  = '0;
    req5  = '0;
    done5 = '0;
    step();
    reset = 1'b0;
  endtask

  // Reset state, then a lone request gets a one-cycle grant.
  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    done  = '0;
    #1;
    n_total++;
    if ({grant, waiting, starve, ptr} !== 14'd0)
      $display("FAIL reset_outputs: got %b/%b/%b/%0d want 0/0/0/0", grant, waiting, starve, ptr);
    else n_pass++;
    step();
    reset = 1'b0;
    req   = 4'b0001;
    step();
    n_total++;
    if (grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", grant);
    else n_pass++;
    n_total++;
    if (ptr !== 2'd1) $display("FAIL single_ptr: got %0d want 1", ptr);
    else n_pass++;
    n_total++;
    if (waiting !== 4'b0000) $display("FAIL single_waiting: got %b want 0000", waiting);
    else n_pass++;
  endtask

  // All hungry from idle, then release and hand over to the odd seats.
  task automatic test_all_hungry();
    apply_reset();
    req = 4'b1111;
    step();
    n_total++;
    if (grant !== 4'b0101) $display("FAIL all_grant: got %b want 0101", grant);
    else n_pass++;
    n_total++;
    if (waiting !== 4'b1010) $display("FAIL all_waiting: got %b want 1010", waiting);
    else n_pass++;
    n_total++;
    if (ptr !== 2'd3) $display("FAIL all_ptr: got %0d want 3", ptr);
    else n_pass++;
    done = 4'b0101;
    step();
    done = 4'b0000;
    // Releasing seats are still eating during the scan of the done edge.
    n_total++;
    if (grant !== 4'b0000) $display("FAIL release_gap: got %b want 0000", grant);
    else n_pass++;
    n_total++;
    if (ptr !== 2'd3) $display("FAIL release_ptr_hold: got %0d want 3", ptr);
    else n_pass++;
    step();
    n_total++;
    if (grant !== 4'b1010) $display("FAIL handover_grant: got %b want 1010", grant);
    else n_pass++;
    // Scan order 3,0,1,2: seat 1 is the last granted, so the pointer lands on 2.
    n_total++;
    if (ptr !== 2'd2) $display("FAIL handover_ptr: got %0d want 2", ptr);
    else n_pass++;
    n_total++;
    if (waiting !== 4'b0101) $display("FAIL handover_waiting: got %b want 0101", waiting);
    else n_pass++;
  endtask

  // Seat 1 eats forever while 0 and 2 wait; counters saturate, withdraw, rejoin.
  task automatic test_starve();
    apply_reset();
    req = 4'b0010;
    step();
    n_total++;
    if (grant !== 4'b0010) $display("FAIL starve_setup: got %b want 0010", grant);
    else n_pass++;
    req = 4'b0101;  // seat 1 drops req while eating; it must keep its grant
    step(11);
    n_total++;
    if (starve !== 4'b0000) $display("FAIL starve_before_limit: got %b want 0000", starve);
    else n_pass++;
    n_total++;
    if (waiting !== 4'b0101 || grant !== 4'b0010)
      $display("FAIL starve_wait_state: got w=%b g=%b want w=0101 g=0010", waiting, grant);
    else n_pass++;
    step();
    n_total++;
    if (starve !== 4'b0101) $display("FAIL starve_at_limit: got %b want 0101", starve);
    else n_pass++;
    step(20);
    n_total++;
    if (starve !== 4'b0101) $display("FAIL starve_saturate: got %b want 0101", starve);
    else n_pass++;

    req = 4'b0100;  // seat 0 withdraws
    step();
    n_total++;
    if (waiting !== 4'b0100) $display("FAIL withdraw_waiting: got %b want 0100", waiting);
    else n_pass++;
    n_total++;
    if (starve !== 4'b0100) $display("FAIL withdraw_starve: got %b want 0100", starve);
    else n_pass++;
    req = 4'b0101;  // seat 0 rejoins with a fresh counter
    step(11);
    n_total++;
    if (starve !== 4'b0100) $display("FAIL rejoin_count: got %b want 0100", starve);
    else n_pass++;
    step();
    n_total++;
    if (starve !== 4'b0101) $display("FAIL rejoin_limit: got %b want 0101", starve);
    else n_pass++;

    done = 4'b0010;
    step();
    done = 4'b0000;
    n_total++;
    if (grant !== 4'b0000 || waiting !== 4'b0101)
      $display("FAIL starve_release: got g=%b w=%b want g=0000 w=0101", grant, waiting);
    else n_pass++;
    step();
    // ptr was 2 after granting seat 1; scan 2,3,0,1 grants 2 then 0.
    n_total++;
    if (grant !== 4'b0101) $display("FAIL starve_served: got %b want 0101", grant);
    else n_pass++;
    n_total++;
    if (ptr !== 2'd1) $display("FAIL starve_served_ptr: got %0d want 1", ptr);
    else n_pass++;
    n_total++;
    if (starve !== 4'b0000) $display("FAIL starve_cleared: got %b want 0000", starve);
    else n_pass++;
    // done on a seat that is not eating is ignored
    req  = 4'b0101;
    done = 4'b1000;
    step();
    done = 4'b0000;
    n_total++;
    if (grant !== 4'b0101) $display("FAIL stray_done: got %b want 0101", grant);
    else n_pass++;
  endtask

  // Asynchronous reset drops grants without an edge; re-arbitration from 0.
  task automatic test_reset_mid();
    apply_reset();
    req = 4'b1010;
    step();
    n_total++;
    if (grant !== 4'b1010) $display("FAIL mid_setup: got %b want 1010", grant);
    else n_pass++;
    req = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (grant !== 4'b0000) $display("FAIL mid_grant_drop: got %b want 0000", grant);
    else n_pass++;
    n_total++;
    if (ptr !== 2'd0) $display("FAIL mid_ptr_clear: got %0d want 0", ptr);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    step();
    n_total++;
    if (grant !== 4'b0101) $display("FAIL mid_rearb: got %b want 0101", grant);
    else n_pass++;
    n_total++;
    if (ptr !== 2'd3) $display("FAIL mid_rearb_ptr: got %0d want 3", ptr);
    else n_pass++;
  endtask

  // 5-seat random run with philosopher models; invariants every cycle.
  task automatic test_random();
    int eat_left [5];
    int think    [5];
    bit eating   [5];
    int wait_len [5];
    int max_wait [5];
    logic [4:0] rot;
    bit adj_reported;
    bit cnt_reported;
    bit mux_reported;
    bit ptr_reported;
    adj_reported = 0;
    cnt_reported = 0;
    mux_reported = 0;
    ptr_reported = 0;
    apply_reset();
    for (int j = 0; j < 5; j++) begin
      eat_left[j] = 0;
      think[j]    = $urandom_range(0, 3);
      eating[j]   = 0;
      wait_len[j] = 0;
      max_wait[j] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      step();
      rot = {grant5[3:0], grant5[4]};
      n_total++;
      if ((grant5 & rot) !== 5'b0) begin
        if (!adj_reported) $display("FAIL rand_adjacent: cycle %0d grant %b", c, grant5);
        adj_reported = 1;
      end else n_pass++;
      n_total++;
      if ($countones(grant5) > 2) begin
        if (!cnt_reported) $display("FAIL rand_grant_count: cycle %0d got %0d want <=2", c, $countones(grant5));
        cnt_reported = 1;
      end else n_pass++;
      n_total++;
      if ((grant5 & waiting5) !== 5'b0) begin
        if (!mux_reported) $display("FAIL rand_grant_wait: cycle %0d g=%b w=%b", c, grant5, waiting5);
        mux_reported = 1;
      end else n_pass++;
      n_total++;
      if (ptr5 > 3'd4) begin
        if (!ptr_reported) $display("FAIL rand_ptr_range: cycle %0d got %0d want <=4", c, ptr5);
        ptr_reported = 1;
      end else n_pass++;

      for (int j = 0; j < 5; j++) begin
        done5[j] = 1'b0;
        if (grant5[j]) begin
          wait_len[j] = 0;
          if (!eating[j]) begin
            eating[j]   = 1;
            eat_left[j] = $urandom_range(0, 2);
          end
          if (eat_left[j] == 0) begin
            done5[j]  = 1'b1;
            req5[j]   = 1'b0;
            eating[j] = 0;
            think[j]  = $urandom_range(0, 3);
          end else begin
            eat_left[j]--;
          end
        end else begin
          if ($urandom_range(0, 9) == 0) done5[j] = 1'b1;  // stray release
          if (req5[j]) begin
            wait_len[j]++;
            if (wait_len[j] > max_wait[j]) max_wait[j] = wait_len[j];
          end else if (think[j] == 0) begin
            req5[j] = 1'b1;
          end else begin
            think[j]--;
          end
        end
      end
    end
    for (int j = 0; j < 5; j++) begin
      n_total++;
      if (max_wait[j] > 100) $display("FAIL rand_wait_bound seat %0d: got %0d want <=100", j, max_wait[j]);
      else n_pass++;
    end
    req5  = '0;
    done5 = '0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    req     = '0;
    done    = '0;
    req5    = '0;
    done5   = '0;
    test_reset();
    test_all_hungry();
    test_starve();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
